// File: rtl/fetch_pkg.sv
// Shared widths, constants and the fetch-queue entry type for the fetch stage.
package fetch_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int IMEM_AW = 16;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    // One buffered fetch result: the byte PC and the word the ROM returned for it.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries. flush empties it and has priority
// over push and pop. Reset also clears the storage so the head reads zero.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 3,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    output logic [CNT_W-1:0]   count,
    output fetch_entry_t       head
);

    fetch_entry_t      mem_q [DEPTH];
    fetch_entry_t      mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Next-state: flush wins; otherwise push writes at wr_ptr and pop advances rd_ptr.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Register update with synchronous reset clearing storage and pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the 1-cycle-latency ROM,
// pairs each returned word with its PC in a small queue and hands entries
// to decode. A redirect flushes everything and restarts at the new PC.
//
// Output handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both high. out_valid never depends on out_ready, and while
// out_valid is high and out_ready low the head {out_pc, out_instr} is held.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [IMEM_AW-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]   imem_q,
    input  logic                 redirect_valid,
    input  logic [PC_W-1:0]      redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [INSTR_W-1:0]   out_instr
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  req_pc_q, req_pc_d;
    logic             req_vld_q, req_vld_d;
    logic [PC_W-1:0]  redir_pc;
    logic [CNT_W:0]   occupancy;
    logic             issue;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;

    // Issue decision uses registered terms only, keeping out_ready off the address path;
    // counting the in-flight request guarantees the queue has room when it returns.
    always_comb begin
        redir_pc   = redirect_pc & ~32'h3;
        occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, req_vld_q};
        issue      = occupancy < (CNT_W + 1)'(DEPTH);
        push       = req_vld_q && !redirect_valid;
        out_valid  = (count != '0) && !redirect_valid;
        pop        = out_valid && out_ready;
        imem_addr  = redirect_valid ? redir_pc[17:2] : fetch_pc_q[17:2];
        push_entry = '{pc: req_pc_q, instr: imem_q};
    end

    // PC sequencing: a redirect restarts the request stream, otherwise step by 4 while issuing.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        req_vld_d  = 1'b0;
        if (redirect_valid) begin
            req_pc_d   = redir_pc;
            req_vld_d  = 1'b1;
            fetch_pc_d = redir_pc + PC_STEP;
        end else if (issue) begin
            req_pc_d   = fetch_pc_q;
            req_vld_d  = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
    end

    // PC and in-flight request registers; reset overrides any redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            req_vld_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            req_vld_q  <= req_vld_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    assign out_pc    = head.pc;
    assign out_instr = head.instr;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a ROM model, directed scenarios, then random
// ready/redirect/reset traffic. The reference model is the ideal fetch stream:
// after a reset or redirect to P, decode must see P, P+4, P+8, ... with the
// ROM word for each PC, in order, with nothing stale in between.
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] imem_addr;
    logic [31:0] imem_q = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int tests = 0;
    int fails = 0;
    int hs_cnt = 0;

    logic [63:0] exp_q[$];
    logic [31:0] fill_pc = 32'h0;

    logic        hold_prev = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_instr = 32'h0;

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (3)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_q         (imem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    // Clock.
    always #5 clock = ~clock;

    // ROM: word[i] = A000_0000 | i, registered read.
    always @(posedge clock) imem_q <= 32'hA000_0000 | {16'h0, imem_addr};

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        logic [15:0] w;
        w = pc[17:2];
        return 32'hA000_0000 | {16'h0, w};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Keep the expected stream topped up from the model's next PC.
    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back({fill_pc, rom_word(fill_pc)});
            fill_pc = fill_pc + 32'd4;
        end
    endtask

    task automatic model_restart(input logic [31:0] pc);
        exp_q.delete();
        fill_pc = {pc[31:2], 2'b00};
        refill();
    endtask

    task automatic drive_reset();
        reset = 1'b1;
        model_restart(32'h0);
    endtask

    task automatic drive_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        model_restart(pc);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Monitor: pops the model stream on every handshake and checks head stability under stall.
    always @(negedge clock) begin
        if (reset) begin
            hold_prev = 1'b0;
        end else if (redirect_valid) begin
            chk("valid_low_on_redirect", {31'h0, out_valid}, 32'h0);
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("stall_valid", {31'h0, out_valid}, 32'h1);
                chk("stall_pc", out_pc, prev_pc);
                chk("stall_instr", out_instr, prev_instr);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL stream_empty: got pc %h expected no transfer", out_pc);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("stream_pc", out_pc, e[63:32]);
                    chk("stream_instr", out_instr, e[31:0]);
                    hs_cnt++;
                end
            end
            hold_prev  = out_valid && !out_ready;
            prev_pc    = out_pc;
            prev_instr = out_instr;
        end
    end

    initial begin
        // Reset state.
        drive_reset();
        cyc();
        @(negedge clock);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_addr", {16'h0, imem_addr}, 32'h0);

        // 1: first-fetch latency and back-to-back stream.
        cyc();
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        chk("t1_c0_valid", {31'h0, out_valid}, 32'h0);
        cyc();
        @(negedge clock);
        chk("t1_c1_valid", {31'h0, out_valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            refill();
            @(negedge clock);
            chk("t1_valid", {31'h0, out_valid}, 32'h1);
            chk("t1_pc", out_pc, 32'(4 * k));
            chk("t1_instr", out_instr, 32'hA000_0000 | 32'(k));
        end

        // 2: stall from reset, three entries buffered, then drain without gaps.
        cyc();
        drive_reset();
        out_ready = 1'b0;
        cyc();
        reset = 1'b0;
        for (int c = 1; c < 8; c++) begin
            cyc();
            @(negedge clock);
            if (c >= 2) begin
                chk("t2_hold_valid", {31'h0, out_valid}, 32'h1);
                chk("t2_hold_pc", out_pc, 32'h0);
            end
        end
        chk("t2_count_full", 32'(dut.count), 32'd3);
        chk("t2_req_idle", {31'h0, dut.req_vld_q}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            out_ready = 1'b1;
            refill();
            @(negedge clock);
            chk("t2_drain_valid", {31'h0, out_valid}, 32'h1);
            chk("t2_drain_pc", out_pc, 32'(4 * k));
        end

        // 3: redirect with two entries queued.
        cyc();
        drive_reset();
        out_ready = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        cyc();
        drive_redirect(32'h0000_0100);
        out_ready = 1'b1;
        @(negedge clock);
        chk("t3_setup_count", 32'(dut.count), 32'd2);
        chk("t3_t_valid", {31'h0, out_valid}, 32'h0);
        chk("t3_t_addr", {16'h0, imem_addr}, 32'h0000_0040);
        cyc();
        redirect_valid = 1'b0;
        @(negedge clock);
        chk("t3_t1_valid", {31'h0, out_valid}, 32'h0);
        cyc();
        refill();
        @(negedge clock);
        chk("t3_t2_valid", {31'h0, out_valid}, 32'h1);
        chk("t3_t2_pc", out_pc, 32'h0000_0100);
        chk("t3_t2_instr", out_instr, 32'hA000_0040);
        cyc();
        refill();
        @(negedge clock);
        chk("t3_t3_pc", out_pc, 32'h0000_0104);

        // 4: low PC bits ignored.
        cyc();
        drive_redirect(32'h0000_0103);
        @(negedge clock);
        chk("t4_addr", {16'h0, imem_addr}, 32'h0000_0040);
        cyc();
        redirect_valid = 1'b0;
        cyc();
        refill();
        @(negedge clock);
        chk("t4_pc", out_pc, 32'h0000_0100);
        chk("t4_instr", out_instr, 32'hA000_0040);

        // 5: 32-bit PC wrap and ROM address wrap.
        cyc();
        drive_redirect(32'hFFFF_FFFC);
        @(negedge clock);
        chk("t5_addr0", {16'h0, imem_addr}, 32'h0000_FFFF);
        cyc();
        redirect_valid = 1'b0;
        @(negedge clock);
        chk("t5_addr1", {16'h0, imem_addr}, 32'h0000_0000);
        cyc();
        refill();
        @(negedge clock);
        chk("t5_pc0", out_pc, 32'hFFFF_FFFC);
        chk("t5_instr0", out_instr, 32'hA000_FFFF);
        cyc();
        refill();
        @(negedge clock);
        chk("t5_pc1", out_pc, 32'h0000_0000);
        chk("t5_instr1", out_instr, 32'hA000_0000);

        // 6: reset and redirect together with a full queue; reset wins.
        cyc();
        out_ready = 1'b0;
        repeat (6) cyc();
        @(negedge clock);
        chk("t6_full", 32'(dut.count), 32'd3);
        cyc();
        drive_redirect(32'h0000_0200);
        drive_reset();
        cyc();
        reset = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        chk("t6_c0_valid", {31'h0, out_valid}, 32'h0);
        chk("t6_c0_count", 32'(dut.count), 32'd0);
        cyc();
        @(negedge clock);
        chk("t6_c1_valid", {31'h0, out_valid}, 32'h0);
        cyc();
        refill();
        @(negedge clock);
        chk("t6_c2_valid", {31'h0, out_valid}, 32'h1);
        chk("t6_c2_pc", out_pc, 32'h0);
        chk("t6_c2_instr", out_instr, 32'hA000_0000);

        // Random traffic against the stream model.
        for (int n = 0; n < 1500; n++) begin
            int r;
            cyc();
            reset = 1'b0;
            redirect_valid = 1'b0;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                drive_reset();
            end else if (r < 10) begin
                if ($urandom_range(0, 3) == 0) begin
                    drive_redirect(32'hFFFF_FFF0 | ($urandom & 32'hF));
                end else begin
                    drive_redirect($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            refill();
        end
        cyc();
        reset = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            cyc();
            refill();
        end
        @(negedge clock);
        tests++;
        if (hs_cnt < 100) begin
            fails++;
            $display("FAIL handshake_count: got %0d expected at least 100", hs_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
